// File: rtl/stamped_rx_pkg.sv
// rtl/stamped_rx_pkg.sv - register map, FIFO entry layout and byte saturation for stamped_rx_buffer
// Timestamp fields of rx_entry_t are only stored when STAMP_CAPTURE_EN is defined.
package stamped_rx_pkg;

  localparam int unsigned REG_STATUS = 0;
  localparam int unsigned REG_COUNT  = 1;
  localparam int unsigned REG_DATA   = 2;
  localparam int unsigned REG_ACQ    = 3;
  localparam int unsigned REG_MS_LO  = 4;
  localparam int unsigned REG_MS_HI  = 5;
  localparam int unsigned REG_SEC0   = 6;
  localparam int unsigned REG_SEC1   = 7;
  localparam int unsigned REG_SEC2   = 8;
  localparam int unsigned REG_SEC3   = 9;
  localparam int unsigned REG_CTRL   = 10;
  localparam int unsigned REG_THRESH = 11;

  localparam int unsigned STATUS_OVF_BIT = 2;

  typedef struct packed {
    logic [7:0]  ch;
    logic [3:0]  acq;
    logic [11:0] ms;
    logic [31:0] sec;
  } rx_entry_t;

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/stamp_fifo.sv
// rtl/stamp_fifo.sv - synchronous FIFO with full/empty/count; pointers wrap modulo DEPTH
// A push while full is accepted only when a pop happens in the same cycle.
module stamp_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/stamped_rx_buffer.sv
// rtl/stamped_rx_buffer.sv - UART receive FIFO with per-character timestamps behind a CPU register port
// Define STAMP_CAPTURE_EN to store and expose timestamps; otherwise only characters are kept.
module stamped_rx_buffer
  import stamped_rx_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CHAR_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHAR_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic [3:0]        acqurate_stamp,
  input  logic [11:0]       millisecond_stamp,
  input  logic [31:0]       second_stamp,
  input  logic [ADDR_W-1:0] AddrBus,
  input  logic              n_ChipSelect,
  input  logic              n_rd,
  input  logic              n_we,
  input  logic [7:0]        DataBusI,
  output logic [7:0]        DataBusO,
  output logic              p_IrqSig
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef STAMP_CAPTURE_EN
  localparam int ENTRY_W = $bits(rx_entry_t);
`else
  localparam int ENTRY_W = 8;
`endif

  logic [ENTRY_W-1:0] wr_entry, rd_entry;
  rx_entry_t          head;
  logic               full, empty;
  logic [CNT_W-1:0]   count, count_d;

  logic rd_act, wr_act, rd_act_q, wr_act_q, rd_strobe, wr_strobe;
  logic is_data, pop_ok, push_ok, ovf_set;
  logic ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic [7:0] thresh_q, thresh_d, dbo_q, rd_val, count8_d;

`ifdef STAMP_CAPTURE_EN
  assign wr_entry = {8'(rx_data), acqurate_stamp, millisecond_stamp, second_stamp};
`else
  logic unused_stamps;
  assign unused_stamps = ^{acqurate_stamp, millisecond_stamp, second_stamp};
  assign wr_entry      = 8'(rx_data);
`endif

  stamp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (rx_valid),
    .pop_i   (pop_ok),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // An empty FIFO presents an all-zero head so DATA and stamp reads return 0.
  always_comb begin
    head = '0;
`ifdef STAMP_CAPTURE_EN
    head = rx_entry_t'(rd_entry);
`else
    head.ch = rd_entry;
`endif
    if (empty) head = '0;
  end

  assign rd_act    = !n_ChipSelect && !n_rd;
  assign wr_act    = !n_ChipSelect && !n_we;
  assign rd_strobe = rd_act && !rd_act_q;
  assign wr_strobe = wr_act && !wr_act_q;

  assign is_data = (AddrBus == ADDR_W'(REG_DATA));
  assign pop_ok  = rd_strobe && is_data && !empty;
  assign push_ok = rx_valid && (!full || pop_ok);
  assign ovf_set = rx_valid && full && !pop_ok;
  assign count_d = count + CNT_W'(push_ok) - CNT_W'(pop_ok);

  always_comb begin
    rd_val = '0;
    case (AddrBus)
      ADDR_W'(REG_STATUS): rd_val = {4'b0, irq_q, ovf_q, full, empty};
      ADDR_W'(REG_COUNT):  rd_val = sat8(32'(count));
      ADDR_W'(REG_DATA):   rd_val = head.ch;
      ADDR_W'(REG_ACQ):    rd_val = {4'b0, head.acq};
      ADDR_W'(REG_MS_LO):  rd_val = head.ms[7:0];
      ADDR_W'(REG_MS_HI):  rd_val = {4'b0, head.ms[11:8]};
      ADDR_W'(REG_SEC0):   rd_val = head.sec[7:0];
      ADDR_W'(REG_SEC1):   rd_val = head.sec[15:8];
      ADDR_W'(REG_SEC2):   rd_val = head.sec[23:16];
      ADDR_W'(REG_SEC3):   rd_val = head.sec[31:24];
      ADDR_W'(REG_CTRL):   rd_val = {7'b0, irq_en_q};
      ADDR_W'(REG_THRESH): rd_val = thresh_q;
      default:             rd_val = '0;
    endcase
  end

  // Interrupt is computed from next-state values so it tracks COUNT/ovf without extra lag.
  always_comb begin
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    if (wr_strobe) begin
      case (AddrBus)
        ADDR_W'(REG_STATUS): if (DataBusI[STATUS_OVF_BIT]) ovf_d = 1'b0;
        ADDR_W'(REG_CTRL):   irq_en_d = DataBusI[0];
        ADDR_W'(REG_THRESH): thresh_d = DataBusI;
        default:             ;
      endcase
    end
    if (ovf_set) ovf_d = 1'b1;
    count8_d = sat8(32'(count_d));
    irq_d    = irq_en_d && (((thresh_d != 8'd0) && (count8_d >= thresh_d)) || ovf_d);
  end

  // Edge detectors reset to "active" so an access held through reset needs a fresh assertion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_act_q <= 1'b1;
      wr_act_q <= 1'b1;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= '0;
      dbo_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      rd_act_q <= rd_act;
      wr_act_q <= wr_act;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
      if (rd_strobe) dbo_q <= rd_val;
    end
  end

  assign DataBusO = dbo_q;
  assign p_IrqSig = irq_q;

endmodule

// File: doc/stamped_rx_buffer.md
STAMPED_RX_BUFFER -- requirements
Module: stamped_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, 4..256).
REQ-002 SHALL have parameter CHAR_W, default 8, received character width (5..8).
REQ-003 SHALL have parameter ADDR_W, default 4, CPU address width (>=4).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  async active-low reset.
- rx_data  in  CHAR_W  character from UART receiver.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- acqurate_stamp  in  4  sub-ms time.
- millisecond_stamp  in  12  ms time.
- second_stamp  in  32  s time.
- AddrBus  in  ADDR_W  register address.
- n_ChipSelect  in  1  chip select, active low.
- n_rd  in  1  read, active low.
- n_we  in  1  write, active low.
- DataBusI  in  8  write data.
- DataBusO  out  8  read data.
- p_IrqSig  out  1  interrupt, active high.

Function
REQ-006 SHALL, on rx_valid, push {rx_data, acqurate_stamp, millisecond_stamp, second_stamp} as sampled that cycle.
REQ-007 SHALL derive rd_strobe on the first clk where n_ChipSelect=0 and n_rd=0 (edge-detected); a held access SHALL produce one strobe only.
REQ-008 SHALL derive wr_strobe the same way from n_ChipSelect=0 and n_we=0, capturing DataBusI that cycle.
REQ-009 SHALL register DataBusO one cycle after rd_strobe and hold it until the next rd_strobe.
REQ-010 SHALL map registers: 0 STATUS {irq,ovf,full,empty} in bits 3:0; 1 COUNT; 2 DATA (zero-extended char); 3 acqurate; 4 ms[7:0]; 5 ms[11:8]; 6..9 sec bytes LSB first; 10 CTRL bit0 irq_en; 11 THRESH. Unmapped reads return 0.
REQ-011 SHALL present head-entry stamp fields at addresses 3..9 without popping.
REQ-012 SHALL pop the head entry on rd_strobe at address 2 only.
REQ-013 SHALL, on a DATA read when empty, return 0 and leave pointers unchanged.
REQ-014 SHALL, on push when full without same-cycle pop, drop the entry and set sticky ovf.
REQ-015 SHALL, on simultaneous push and pop, accept both with COUNT unchanged, including when full.
REQ-016 SHALL clear ovf on a write of 1 to STATUS bit2; writes to other STATUS bits are ignored.
REQ-017 SHALL saturate COUNT and THRESH reads/writes to 8 bits; the pointers SHALL wrap modulo DEPTH.
REQ-018 SHALL drive p_IrqSig = irq_en AND (COUNT >= THRESH OR ovf), registered, THRESH=0 meaning never by count.

Reset
REQ-019 SHALL on rst=0 clear pointers, COUNT, ovf, irq_en, THRESH, edge detectors; DataBusO=0; p_IrqSig=0; empty=1.
REQ-020 SHALL, on reset mid-access, require a fresh assertion of n_rd/n_we after release before a strobe.

Configuration
REQ-021 SHALL, with STAMP_CAPTURE_EN defined, store and expose timestamps per REQ-006/REQ-011.
REQ-022 SHALL, without STAMP_CAPTURE_EN, store only the character and read addresses 3..9 as 0.

Structure
REQ-023 SHALL place the register-address constants and the entry struct typedef in package stamped_rx_pkg.
REQ-024 SHALL implement storage as sub-module stamp_fifo (synchronous FIFO, full/empty/count).

Verification
REQ-025 Push chars 0x41,0x42 with sec=0x00010203, ms=0x123 -> reads of addr 9..6 give 00,01,02,03; addr 4,5 give 0x23,0x01; DATA gives 0x41 then 0x42; STATUS empty=1.
REQ-026 Push DEPTH+1 chars -> full=1, ovf=1, COUNT=DEPTH; write 0x04 to STATUS -> ovf=0.
REQ-027 Full FIFO, push coinciding with DATA pop -> COUNT stays DEPTH, ovf=0, newest entry read last.
REQ-028 irq_en=1, THRESH=3, push 3 -> p_IrqSig=1 one cycle after third push; pop one -> p_IrqSig=0.
REQ-029 Hold n_rd low 10 cycles on DATA -> exactly one pop; DATA read when empty -> 0x00.
REQ-030 Assert rst with 5 entries -> COUNT=0, empty=1, DataBusO=0, p_IrqSig=0.
